// File: rtl/gshare_predictor.sv
// Gshare direction predictor: saturating counter table indexed by PC index XOR
// global history, with speculative GHR, commit-time training and a reset-time init sweep.
module gshare_predictor #(
  parameter int IDX_W    = 5,
  parameter int CNT_W    = 2,
  parameter int HIST_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int INIT_CNT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      ready,
  input  logic [NUM_RD*IDX_W-1:0]   rd_idx,
  output logic [NUM_RD-1:0]         pred_taken,
  output logic [HIST_W-1:0]         pred_hist,
  input  logic [NUM_RD-1:0]         spec_push,
  input  logic [NUM_RD-1:0]         spec_dir,
  input  logic                      upd_we,
  input  logic [IDX_W-1:0]          upd_idx,
  input  logic [HIST_W-1:0]         upd_hist,
  input  logic                      upd_taken,
  input  logic                      upd_mispredict
);

  // state   | meaning
  // ST_INIT | sweeping INIT_CNT into every entry; lookups forced not-taken
  // ST_RUN  | table valid; lookups, training and GHR speculation active

  localparam int              DEPTH    = 2**IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(INIT_CNT);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  init_ptr;
  logic [HIST_W-1:0] ghr;
  logic [HIST_W-1:0] ghr_nxt;
  logic [CNT_W-1:0]  cnt_tbl [DEPTH];
  logic [IDX_W-1:0]  upd_w;
  logic [CNT_W-1:0]  upd_cur;
  logic [CNT_W-1:0]  upd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_ptr <= '0;
      ready    <= 1'b0;
      ghr      <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + IDX_W'(1);
          if (init_ptr == IDX_W'(DEPTH - 1)) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: ghr <= ghr_nxt;
        default: state <= ST_INIT;
      endcase
    end
  end

  // A mispredict rebuilds history from the branch's own snapshot; younger pushes are wrong-path.
  always_comb begin
    ghr_nxt = ghr;
    if (upd_we && upd_mispredict) begin
      ghr_nxt = {upd_hist[HIST_W-2:0], upd_taken};
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (spec_push[k]) ghr_nxt = {ghr_nxt[HIST_W-2:0], spec_dir[k]};
      end
    end
  end

  assign upd_w   = upd_idx ^ IDX_W'(upd_hist);
  assign upd_cur = cnt_tbl[upd_w];

  always_comb begin
    upd_nxt = upd_cur;
    if (upd_taken) begin
      if (upd_cur != CNT_MAX) upd_nxt = upd_cur + CNT_W'(1);
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      cnt_tbl[init_ptr] <= CNT_INI;
    end else if (upd_we) begin
      cnt_tbl[upd_w] <= upd_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [IDX_W-1:0] idx;
    assign idx           = rd_idx[k*IDX_W +: IDX_W] ^ IDX_W'(ghr);
    assign pred_taken[k] = ready & cnt_tbl[idx][CNT_W-1];
  end

  assign pred_hist = ghr;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: init sweep, saturation, hashing, GHR push/recovery, reset.
module tb_gshare_predictor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ready;
  logic [9:0] rd_idx;
  logic [1:0] pred_taken;
  logic [4:0] pred_hist;
  logic [1:0] spec_push;
  logic [1:0] spec_dir;
  logic       upd_we;
  logic [4:0] upd_idx;
  logic [4:0] upd_hist;
  logic       upd_taken;
  logic       upd_mispredict;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gshare_predictor #(.IDX_W(5), .CNT_W(2), .HIST_W(5), .NUM_RD(2), .INIT_CNT(1)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .rd_idx(rd_idx), .pred_taken(pred_taken),
    .pred_hist(pred_hist), .spec_push(spec_push), .spec_dir(spec_dir), .upd_we(upd_we),
    .upd_idx(upd_idx), .upd_hist(upd_hist), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    spec_push = '0; spec_dir = '0; upd_we = 0; upd_idx = '0;
    upd_hist = '0; upd_taken = 0; upd_mispredict = 0;
  endtask

  task automatic sweep_and_scan(input string tag);
    for (int i = 1; i <= 32; i++) begin
      step();
      checks++;
      if (ready !== (i == 32)) begin
        errors++;
        $display("FAIL %s_ready cycle %0d: got %b expected %b", tag, i, ready, (i == 32));
      end
      checks++;
      if (pred_hist !== 5'b0) begin
        errors++;
        $display("FAIL %s_ghr_hold cycle %0d: got %b expected 00000", tag, i, pred_hist);
      end
      if (i < 32) begin
        checks++;
        if (pred_taken !== 2'b00) begin
          errors++;
          $display("FAIL %s_pred_forced cycle %0d: got %b expected 00", tag, i, pred_taken);
        end
      end
    end
    clear_inputs();
    for (int i = 0; i < 32; i++) begin
      rd_idx = {5'(31 - i), 5'(i)};
      #1;
      checks++;
      if (pred_taken !== 2'b00) begin
        errors++;
        $display("FAIL %s_scan idx %0d: got %b expected 00", tag, i, pred_taken);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; rd_idx = '0; clear_inputs();
    #2;
    checks++;
    if (ready !== 1'b0 || pred_hist !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b hist=%b expected ready=0 hist=00000", ready, pred_hist);
    end
    step();
    rst_n = 1;
    // Push/mispredict traffic during the sweep must not move the GHR.
    spec_push = 2'b11; spec_dir = 2'b11; upd_we = 1; upd_mispredict = 1;
    upd_hist = 5'b11111; upd_taken = 1; rd_idx = {5'd3, 5'd9};
    sweep_and_scan("init");
  endtask

  task automatic test_saturation();
    rd_idx = {5'd0, 5'd7};
    upd_we = 1; upd_idx = 5'd7; upd_hist = 5'd0; upd_taken = 1;
    #1;
    checks++;
    if (pred_taken[0] !== 1'b0) begin
      errors++;
      $display("FAIL sat_rdw_old: got %b expected 0", pred_taken[0]);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pred_taken[0] !== 1'b1) begin
        errors++;
        $display("FAIL sat_up step %0d: got %b expected 1", i, pred_taken[0]);
      end
    end
    upd_taken = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (pred_taken[0] !== (i == 0)) begin
        errors++;
        $display("FAIL sat_down step %0d: got %b expected %b", i, pred_taken[0], (i == 0));
      end
    end
    upd_we = 0;
  endtask

  task automatic test_hashing();
    spec_push = 2'b01; spec_dir = 2'b01;
    step();
    spec_push = 2'b00; spec_dir = 2'b00;
    checks++;
    if (pred_hist !== 5'b00001) begin
      errors++;
      $display("FAIL hash_push: got %b expected 00001", pred_hist);
    end
    step();
    checks++;
    if (pred_hist !== 5'b00001) begin
      errors++;
      $display("FAIL hash_hold: got %b expected 00001", pred_hist);
    end
    rd_idx = {5'd7, 5'd6};
    #1;
    checks++;
    if (pred_taken !== 2'b00) begin
      errors++;
      $display("FAIL hash_pre: got %b expected 00", pred_taken);
    end
    upd_we = 1; upd_idx = 5'd6; upd_hist = 5'b00001; upd_taken = 1;
    step();
    step();
    upd_we = 0;
    checks++;
    if (pred_taken !== 2'b01) begin
      errors++;
      $display("FAIL hash_trained: got %b expected 01", pred_taken);
    end
    checks++;
    if (pred_hist !== 5'b00001) begin
      errors++;
      $display("FAIL hash_upd_no_ghr: got %b expected 00001", pred_hist);
    end
  endtask

  task automatic test_dual_push();
    upd_we = 1; upd_mispredict = 1; upd_idx = 5'd20; upd_hist = 5'd0; upd_taken = 0;
    step();
    clear_inputs();
    checks++;
    if (pred_hist !== 5'b00000) begin
      errors++;
      $display("FAIL dual_clear: got %b expected 00000", pred_hist);
    end
    spec_push = 2'b11; spec_dir = 2'b10;
    step();
    checks++;
    if (pred_hist !== 5'b00001) begin
      errors++;
      $display("FAIL dual_order: got %b expected 00001", pred_hist);
    end
    spec_dir = 2'b11;
    step();
    checks++;
    if (pred_hist !== 5'b00111) begin
      errors++;
      $display("FAIL dual_two: got %b expected 00111", pred_hist);
    end
    spec_push = 2'b10; spec_dir = 2'b10;
    step();
    spec_push = 2'b00; spec_dir = 2'b00;
    checks++;
    if (pred_hist !== 5'b01111) begin
      errors++;
      $display("FAIL dual_slot1: got %b expected 01111", pred_hist);
    end
  endtask

  task automatic test_recovery();
    upd_we = 1; upd_mispredict = 1; upd_idx = 5'd0; upd_hist = 5'b01011; upd_taken = 0;
    step();
    checks++;
    if (pred_hist !== 5'b10110) begin
      errors++;
      $display("FAIL rec_setup: got %b expected 10110", pred_hist);
    end
    upd_idx = 5'd3; upd_hist = 5'b01010; upd_taken = 1;
    spec_push = 2'b11; spec_dir = 2'b11;
    step();
    clear_inputs();
    checks++;
    if (pred_hist !== 5'b10101) begin
      errors++;
      $display("FAIL rec_priority: got %b expected 10101", pred_hist);
    end
    rd_idx = {5'd0, 5'd28};
    #1;
    checks++;
    if (pred_taken[0] !== 1'b1) begin
      errors++;
      $display("FAIL rec_entry9: got %b expected 1", pred_taken[0]);
    end
    upd_we = 1; upd_idx = 5'd0; upd_hist = 5'b11111; upd_taken = 1;
    step();
    upd_we = 0;
    checks++;
    if (pred_hist !== 5'b10101) begin
      errors++;
      $display("FAIL rec_upd_no_ghr: got %b expected 10101", pred_hist);
    end
    rd_idx = {5'd0, 5'd10};
    #1;
    checks++;
    if (pred_taken[0] !== 1'b1) begin
      errors++;
      $display("FAIL rec_entry31: got %b expected 1", pred_taken[0]);
    end
    upd_mispredict = 1; upd_hist = 5'd0; upd_taken = 0;
    step();
    clear_inputs();
    checks++;
    if (pred_hist !== 5'b10101) begin
      errors++;
      $display("FAIL rec_mis_no_we: got %b expected 10101", pred_hist);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 0;
    #2;
    checks++;
    if (ready !== 1'b0 || pred_hist !== 5'b0) begin
      errors++;
      $display("FAIL rst_run_async: got ready=%b hist=%b expected ready=0 hist=00000", ready, pred_hist);
    end
    step();
    rst_n = 1;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL rst_partial cycle %0d: got %b expected 0", i, ready);
      end
    end
    rst_n = 0;
    #1;
    checks++;
    if (ready !== 1'b0 || pred_hist !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got ready=%b hist=%b expected ready=0 hist=00000", ready, pred_hist);
    end
    step();
    rst_n = 1;
    sweep_and_scan("resweep");
    // One taken step from INIT_CNT=1 must reach the taken half.
    upd_we = 1; upd_idx = 5'd31; upd_hist = 5'd0; upd_taken = 1;
    step();
    upd_we = 0;
    rd_idx = {5'd30, 5'd31};
    #1;
    checks++;
    if (pred_taken !== 2'b01) begin
      errors++;
      $display("FAIL rst_init_value: got %b expected 01", pred_taken);
    end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_hashing();
    test_dual_push();
    test_recovery();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor of the 5-bit-index bimodal table: a gshare direction predictor for the superscalar fetch stage.
- Table of saturating CNT_W-bit counters, indexed by PC index XOR global history.
- Provides NUM_RD same-cycle lookups, a speculative global history register (GHR), commit-time update with history recovery on mispredict, and a post-reset table-initialisation sweep.

Parameters:
- IDX_W, 5, table index width; DEPTH = 2**IDX_W entries
- CNT_W, 2, counter width (>=2)
- HIST_W, 5, GHR width (<= IDX_W); folded into the low HIST_W index bits
- NUM_RD, 2, lookup ports per cycle
- INIT_CNT, 1, counter value written by the reset sweep (weakly not-taken)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ready  out  1  table initialised; lookups and updates valid
- rd_idx  in  NUM_RD*IDX_W  PC-derived index per slot; slot k = bits [k*IDX_W +: IDX_W]
- pred_taken  out  NUM_RD  predicted direction per slot
- pred_hist  out  HIST_W  GHR value used for this cycle's lookups (carried down the pipe)
- spec_push  in  NUM_RD  per-slot: shift that slot's predicted direction into the GHR
- spec_dir  in  NUM_RD  direction shifted in per pushed slot
- upd_we  in  1  commit a resolved branch
- upd_idx  in  IDX_W  PC index of the resolved branch
- upd_hist  in  HIST_W  pred_hist captured when that branch was predicted
- upd_taken  in  1  actual direction
- upd_mispredict  in  1  direction was mispredicted; restore GHR

Behaviour:
- Reset (rst_n=0, asynchronous): GHR=0, state=INIT, init_ptr=0, ready=0. Table contents undefined until the sweep completes. Asserting rst_n at any point, including mid-sweep, restarts from this state.
- INIT state:
  - Each posedge writes INIT_CNT to table[init_ptr], then init_ptr++.
  - The posedge that writes entry DEPTH-1 moves the state to RUN and sets ready=1. ready is registered, so it rises exactly DEPTH cycles after the first posedge with rst_n=1.
  - In INIT: pred_taken is forced to 0, upd_we is ignored, spec_push is ignored, and the GHR holds 0.
- RUN state: stays in RUN until reset.
- Lookup (combinational, zero latency):
  - idx_k = rd_idx[k] XOR {0, GHR}, with the GHR zero-extended to IDX_W.
  - pred_taken[k] = MSB of table[idx_k].
  - All slots use the same registered GHR. pred_hist = GHR.
- Update (RUN, upd_we=1), on posedge:
  - w = upd_idx XOR {0, upd_hist}.
  - If upd_taken: table[w] = min(cnt+1, 2**CNT_W-1). Otherwise: table[w] = max(cnt-1, 0).
  - Saturation is mandatory: no wrap from max to 0 or from 0 to max.
- Read-during-write to the same entry: the lookup returns the pre-update value, and the new value is visible the next cycle.
- GHR next-state (RUN), in priority order:
  - upd_we & upd_mispredict: GHR = {upd_hist[HIST_W-2:0], upd_taken}. spec_push is discarded that cycle (wrong path).
  - Otherwise, for k = 0..NUM_RD-1 in ascending order: if spec_push[k], GHR = {GHR[HIST_W-2:0], spec_dir[k]}. Slot 0 is the older branch. Multiple pushes shift by the push count in one cycle.
  - Otherwise: GHR holds.
- upd_we=1 with upd_mispredict=0 updates the table only; the GHR is unaffected by the update path.
- upd_mispredict is ignored when upd_we=0.

Test Plan:
- Init sweep: release rst_n, DEPTH=32 → ready=0 for 32 cycles, then 1 on cycle 32. Every index reads pred_taken=0. Checked with GHR=0 via index scan.
- Saturation: RUN, GHR=0, 3 taken updates on upd_idx=7 → counter 1→2→3→3; pred_taken[0]=1 for rd_idx=7. Then 4 not-taken updates → 3→2→1→0→0, pred_taken=0.
- History hashing: spec_push=2'b01, spec_dir=2'b01 → GHR=00001. rd_idx=6 reads entry 7. Train entry 7 taken via upd_idx=6, upd_hist=00001 → pred_taken=1 at rd_idx=6 but 0 at rd_idx=7.
- Dual push order: GHR=00000, spec_push=11, spec_dir={1,0} (slot1=1, slot0=0) → GHR=00001. Next cycle spec_push=11, spec_dir=11 → GHR=00111.
- Recovery priority: GHR=10110, same cycle upd_we=1, upd_mispredict=1, upd_hist=01010, upd_taken=1, spec_push=11 → GHR=10101 next cycle. Table entry upd_idx^01010 is incremented.
- Reset mid-operation: assert rst_n low during RUN with GHR≠0 and mid-sweep at init_ptr=12 → ready=0 and GHR=0 immediately without a clock edge. After release, the full 32-cycle sweep repeats and all entries read INIT_CNT.
